phase_sequencer: RTL and testbench
==================================

Name: phase_sequencer

Overview:
- Control-phase generator and instruction register that sits directly upstream of the instruction decoder.
- Latches the 16-bit instruction word from program ROM and produces the one-hot phase strobes fetch/exec1/exec2/exec3 that the decoder consumes.
- Sequences each instruction's length from the decoder's extra/extra2 feedback.
- Provides run/halt/single-step control, STP handling and a retired-instruction counter.

Parameters:
- IW, 16: instruction width. Opcode field is instr[IW-1:IW-5].
- START_RUNNING, 1: 1 = leave reset in FETCH; 0 = leave reset in HALT.
- RETIRE_W, 16: width of the retired-instruction counter.

Ports:
- clk  in  1  system clock, rising edge.
- reset  in  1  synchronous, active-high reset.
- instr_in  in  IW  instruction word from program ROM, valid during FETCH.
- extra  in  1  from decoder: instruction needs EXEC2.
- extra2  in  1  from decoder: instruction needs EXEC3. Meaningful only with extra=1.
- start  in  1  one-cycle pulse: resume continuous execution from HALT.
- step  in  1  one-cycle pulse: execute exactly one instruction from HALT.
- halt_req  in  1  one-cycle pulse: halt after the current instruction completes.
- instr  out  IW  instruction register, feeds the decoder.
- fetch  out  1  phase strobe.
- exec1  out  1  phase strobe.
- exec2  out  1  phase strobe.
- exec3  out  1  phase strobe.
- ir_load  out  1  high in FETCH; IR captures instr_in at the end of this cycle.
- instr_done  out  1  high during the final phase of an instruction.
- halted  out  1  high in HALT.
- retire_cnt  out  RETIRE_W  count of completed instructions. Wraps.

Behaviour:
- States: FETCH, EXEC1, EXEC2, EXEC3, HALT. Exactly one of fetch/exec1/exec2/exec3/halted is high every cycle. All are decoded from the state register, so no combinational path runs from inputs.
- Reset: state = START_RUNNING ? FETCH : HALT. instr = 0, retire_cnt = 0, pend_halt = 0, step_mode = 0. A reset mid-instruction abandons it with no retire increment.
- FETCH: ir_load = 1, IR <= instr_in. Next state EXEC1.
- EXEC1:
  - If instr[IW-1:IW-5] = 5'b11110 (STP): instruction is done, next state HALT regardless of pend_halt or step_mode.
  - Else if extra = 0: instruction is done.
  - Else next state EXEC2.
- EXEC2: if extra2 = 1, next state EXEC3; else instruction is done.
- EXEC3: instruction is done.
- On done:
  - instr_done = 1 and retire_cnt increments at the end of that cycle (STP counts).
  - Next state is HALT if pend_halt, step_mode, halt_req or STP; otherwise FETCH.
- Instruction lengths are 2, 3 or 4 cycles. IR is stable from EXEC1 through the last phase.
- halt_req while not in HALT sets sticky pend_halt. pend_halt clears on entry to HALT. halt_req in HALT is ignored.
- HALT: IR holds, all phase strobes are 0, halted = 1.
  - start → FETCH next cycle with step_mode = 0.
  - step (with start = 0) → FETCH with step_mode = 1.
  - start and step in the same cycle: start wins.
  - start and step outside HALT are ignored.
- halt_req and start in the same cycle while running: halt wins. In HALT, halt_req has no effect and start resumes.
- Resuming after STP re-fetches STP, because the decoder does not advance the PC on STP. The block returns to HALT two cycles later and retire_cnt increments again. This is required behaviour.
- retire_cnt wraps from all-ones to 0 with no flag.

Test Plan:
- START_RUNNING=1, instr_in=16'h2000 (STA), extra=0 → fetch, exec1 alternate. retire_cnt = 1, 2, 3 at cycles 2, 4, 6 after reset release. instr = 16'h2000 from cycle 1.
- instr_in=16'h0000, extra=1, extra2=0 → fetch, exec1, exec2 repeating. instr_done only in exec2. retire_cnt +1 per 3 cycles.
- instr_in=16'h4000, extra=1, extra2=1 → 4-cycle repeat fetch, exec1, exec2, exec3. Pulse halt_req in exec2 → exec3 completes, halted = 1 next cycle, retire_cnt +1. start pulse → fetch on the following cycle.
- instr_in=16'hF000 (STP) → fetch, exec1, then halted = 1 and held with retire_cnt = 1. start → fetch, exec1, halted, retire_cnt = 2.
- In HALT, step pulse with instr_in=16'h8000, extra=0 → exactly fetch, exec1, then halted. Same cycle start + step → continuous run with no return to HALT.
- Preload retire_cnt near wrap (RETIRE_W=4, run 16 two-cycle instructions) → count reaches 15 then 0. Assert reset during exec2 → next cycle is FETCH, retire_cnt = 0, instr = 0.

Source files
------------

// File: rtl/phase_sequencer.sv
//------------------------------------------------------------------------------
// phase_sequencer : instruction register and one-hot phase generator
// Rev 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module phase_sequencer #(
   parameter int IW            = 16,
   parameter int START_RUNNING = 1,
   parameter int RETIRE_W      = 16
) (
   input  logic                clk,
   input  logic                reset,
   input  logic [IW-1:0]       instr_in,
   input  logic                extra,
   input  logic                extra2,
   input  logic                start,
   input  logic                step,
   input  logic                halt_req,
   output logic [IW-1:0]       instr,
   output logic                fetch,
   output logic                exec1,
   output logic                exec2,
   output logic                exec3,
   output logic                ir_load,
   output logic                instr_done,
   output logic                halted,
   output logic [RETIRE_W-1:0] retire_cnt
);

   localparam logic [4:0] OP_STP = 5'b11110;

   typedef enum logic [2:0] {
      S_FETCH = 3'd0,
      S_EXEC1 = 3'd1,
      S_EXEC2 = 3'd2,
      S_EXEC3 = 3'd3,
      S_HALT  = 3'd4
   } state_t;

   localparam state_t RESET_STATE = (START_RUNNING != 0) ? S_FETCH : S_HALT;

   state_t                state_q,      state_d;
   logic [IW-1:0]         instr_q,      instr_d;
   logic [RETIRE_W-1:0]   retire_cnt_q, retire_cnt_d;
   logic                  pend_halt_q,  pend_halt_d;
   logic                  step_mode_q,  step_mode_d;
   logic                  done;
   logic                  is_stp;

   always_comb begin
      state_d      = state_q;
      instr_d      = instr_q;
      retire_cnt_d = retire_cnt_q;
      pend_halt_d  = pend_halt_q;
      step_mode_d  = step_mode_q;
      done         = 1'b0;
      is_stp       = (instr_q[IW-1 -: 5] == OP_STP);

      case (state_q)
         S_FETCH: begin
            instr_d = instr_in;
            state_d = S_EXEC1;
         end
         S_EXEC1: begin
            if (is_stp || !extra) done = 1'b1;
            else                  state_d = S_EXEC2;
         end
         S_EXEC2: begin
            if (extra2) state_d = S_EXEC3;
            else        done    = 1'b1;
         end
         S_EXEC3: done = 1'b1;
         S_HALT: begin
            // start has priority over step when both arrive together
            if (start) begin
               state_d     = S_FETCH;
               step_mode_d = 1'b0;
            end else if (step) begin
               state_d     = S_FETCH;
               step_mode_d = 1'b1;
            end
         end
         default: state_d = RESET_STATE;
      endcase

      if (state_q != S_HALT && halt_req) pend_halt_d = 1'b1;

      if (done) begin
         retire_cnt_d = retire_cnt_q + 1'b1;
         if (pend_halt_q || step_mode_q || halt_req || is_stp) begin
            state_d     = S_HALT;
            pend_halt_d = 1'b0;
         end else begin
            state_d = S_FETCH;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q      <= RESET_STATE;
         instr_q      <= '0;
         retire_cnt_q <= '0;
         pend_halt_q  <= 1'b0;
         step_mode_q  <= 1'b0;
      end else begin
         state_q      <= state_d;
         instr_q      <= instr_d;
         retire_cnt_q <= retire_cnt_d;
         pend_halt_q  <= pend_halt_d;
         step_mode_q  <= step_mode_d;
      end
   end

   assign instr      = instr_q;
   assign retire_cnt = retire_cnt_q;
   assign fetch      = (state_q == S_FETCH);
   assign exec1      = (state_q == S_EXEC1);
   assign exec2      = (state_q == S_EXEC2);
   assign exec3      = (state_q == S_EXEC3);
   assign halted     = (state_q == S_HALT);
   assign ir_load    = (state_q == S_FETCH);
   assign instr_done = done;

endmodule

`default_nettype wire

// File: tb/tb_phase_sequencer.sv
//------------------------------------------------------------------------------
// tb_phase_sequencer : directed self-checking bench for phase_sequencer
// Rev 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module tb_phase_sequencer;

   localparam logic [4:0] P_F  = 5'b10000;
   localparam logic [4:0] P_E1 = 5'b01000;
   localparam logic [4:0] P_E2 = 5'b00100;
   localparam logic [4:0] P_E3 = 5'b00010;
   localparam logic [4:0] P_H  = 5'b00001;

   logic        clk;
   logic        reset, extra, extra2, start, step, halt_req;
   logic [15:0] instr_in;

   logic [15:0] instr;
   logic        fetch, exec1, exec2, exec3, ir_load, instr_done, halted;
   logic [15:0] retire_cnt;

   logic [15:0] h_instr;
   logic        h_fetch, h_exec1, h_exec2, h_exec3, h_ir_load, h_done, h_halted;
   logic [15:0] h_retire;

   logic        w_reset, w_extra, w_extra2;
   logic [15:0] w_instr;
   logic        w_fetch, w_exec1, w_exec2, w_exec3, w_ir_load, w_done, w_halted;
   logic [3:0]  w_retire;

   wire  [4:0]  ph   = {fetch, exec1, exec2, exec3, halted};
   wire  [4:0]  h_ph = {h_fetch, h_exec1, h_exec2, h_exec3, h_halted};
   wire  [4:0]  w_ph = {w_fetch, w_exec1, w_exec2, w_exec3, w_halted};

   int pass_cnt  = 0;
   int total_cnt = 0;
   int exp_ret   = 0;

   phase_sequencer #(.IW(16), .START_RUNNING(1), .RETIRE_W(16)) dut (
      .clk(clk), .reset(reset), .instr_in(instr_in), .extra(extra), .extra2(extra2),
      .start(start), .step(step), .halt_req(halt_req), .instr(instr),
      .fetch(fetch), .exec1(exec1), .exec2(exec2), .exec3(exec3), .ir_load(ir_load),
      .instr_done(instr_done), .halted(halted), .retire_cnt(retire_cnt)
   );

   phase_sequencer #(.IW(16), .START_RUNNING(0), .RETIRE_W(16)) dut_h (
      .clk(clk), .reset(reset), .instr_in(instr_in), .extra(extra), .extra2(extra2),
      .start(start), .step(step), .halt_req(halt_req), .instr(h_instr),
      .fetch(h_fetch), .exec1(h_exec1), .exec2(h_exec2), .exec3(h_exec3), .ir_load(h_ir_load),
      .instr_done(h_done), .halted(h_halted), .retire_cnt(h_retire)
   );

   phase_sequencer #(.IW(16), .START_RUNNING(1), .RETIRE_W(4)) dut_w (
      .clk(clk), .reset(w_reset), .instr_in(16'h1234), .extra(w_extra), .extra2(w_extra2),
      .start(1'b0), .step(1'b0), .halt_req(1'b0), .instr(w_instr),
      .fetch(w_fetch), .exec1(w_exec1), .exec2(w_exec2), .exec3(w_exec3), .ir_load(w_ir_load),
      .instr_done(w_done), .halted(w_halted), .retire_cnt(w_retire)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic test_reset();
      reset = 1'b1; instr_in = 16'h2000; extra = 1'b0; extra2 = 1'b0;
      start = 1'b0; step = 1'b0; halt_req = 1'b0;
      tick(); tick();
      reset = 1'b0;
      total_cnt++; if (ph !== P_F) $display("FAIL reset_phase act=%b exp=%b", ph, P_F); else pass_cnt++;
      total_cnt++; if (ir_load !== 1'b1) $display("FAIL reset_ir_load act=%b exp=1", ir_load); else pass_cnt++;
      total_cnt++; if (instr !== 16'h0) $display("FAIL reset_instr act=%h exp=0000", instr); else pass_cnt++;
      total_cnt++; if (retire_cnt !== 16'h0) $display("FAIL reset_retire act=%0d exp=0", retire_cnt); else pass_cnt++;
      total_cnt++; if (h_ph !== P_H) $display("FAIL reset_halt_start act=%b exp=%b", h_ph, P_H); else pass_cnt++;
      total_cnt++; if (h_instr !== 16'h0) $display("FAIL reset_halt_instr act=%h exp=0000", h_instr); else pass_cnt++;
   endtask

   task automatic test_two_cycle();
      for (int k = 0; k < 3; k++) begin
         tick();
         total_cnt++; if (ph !== P_E1) $display("FAIL two_cyc_e1 k=%0d act=%b exp=%b", k, ph, P_E1); else pass_cnt++;
         total_cnt++; if (instr !== 16'h2000) $display("FAIL two_cyc_instr k=%0d act=%h exp=2000", k, instr); else pass_cnt++;
         total_cnt++; if (instr_done !== 1'b1) $display("FAIL two_cyc_done k=%0d act=%b exp=1", k, instr_done); else pass_cnt++;
         tick();
         exp_ret++;
         total_cnt++; if (ph !== P_F) $display("FAIL two_cyc_f k=%0d act=%b exp=%b", k, ph, P_F); else pass_cnt++;
         total_cnt++; if (retire_cnt !== 16'(exp_ret)) $display("FAIL two_cyc_retire act=%0d exp=%0d", retire_cnt, exp_ret); else pass_cnt++;
      end
   endtask

   task automatic test_three_cycle();
      instr_in = 16'h0000; extra = 1'b1; extra2 = 1'b0;
      for (int k = 0; k < 2; k++) begin
         tick();
         total_cnt++; if (ph !== P_E1) $display("FAIL three_cyc_e1 act=%b exp=%b", ph, P_E1); else pass_cnt++;
         total_cnt++; if (instr_done !== 1'b0) $display("FAIL three_cyc_done_e1 act=%b exp=0", instr_done); else pass_cnt++;
         tick();
         total_cnt++; if (ph !== P_E2) $display("FAIL three_cyc_e2 act=%b exp=%b", ph, P_E2); else pass_cnt++;
         total_cnt++; if (instr_done !== 1'b1) $display("FAIL three_cyc_done_e2 act=%b exp=1", instr_done); else pass_cnt++;
         tick();
         exp_ret++;
         total_cnt++; if (ph !== P_F) $display("FAIL three_cyc_f act=%b exp=%b", ph, P_F); else pass_cnt++;
         total_cnt++; if (retire_cnt !== 16'(exp_ret)) $display("FAIL three_cyc_retire act=%0d exp=%0d", retire_cnt, exp_ret); else pass_cnt++;
      end
   endtask

   task automatic test_four_cycle_halt();
      instr_in = 16'h4000; extra = 1'b1; extra2 = 1'b1;
      tick(); tick();
      total_cnt++; if (ph !== P_E2) $display("FAIL four_cyc_e2 act=%b exp=%b", ph, P_E2); else pass_cnt++;
      tick();
      total_cnt++; if (ph !== P_E3 || instr_done !== 1'b1) $display("FAIL four_cyc_e3 act=%b/%b exp=%b/1", ph, instr_done, P_E3); else pass_cnt++;
      tick();
      exp_ret++;
      total_cnt++; if (ph !== P_F || retire_cnt !== 16'(exp_ret)) $display("FAIL four_cyc_f act=%b/%0d exp=%b/%0d", ph, retire_cnt, P_F, exp_ret); else pass_cnt++;
      tick(); tick();
      halt_req = 1'b1;
      tick();
      halt_req = 1'b0;
      total_cnt++; if (ph !== P_E3) $display("FAIL halt_req_e3 act=%b exp=%b", ph, P_E3); else pass_cnt++;
      tick();
      exp_ret++;
      total_cnt++; if (ph !== P_H) $display("FAIL halt_req_halted act=%b exp=%b", ph, P_H); else pass_cnt++;
      total_cnt++; if (retire_cnt !== 16'(exp_ret)) $display("FAIL halt_req_retire act=%0d exp=%0d", retire_cnt, exp_ret); else pass_cnt++;
      tick();
      total_cnt++; if (ph !== P_H || instr !== 16'h4000) $display("FAIL halt_hold act=%b/%h exp=%b/4000", ph, instr, P_H); else pass_cnt++;
      start = 1'b1;
      tick();
      start = 1'b0;
      total_cnt++; if (ph !== P_F) $display("FAIL start_fetch act=%b exp=%b", ph, P_F); else pass_cnt++;
   endtask

   task automatic test_stp();
      instr_in = 16'hF000;
      for (int k = 0; k < 2; k++) begin
         tick();
         total_cnt++; if (ph !== P_E1 || instr_done !== 1'b1) $display("FAIL stp_e1 k=%0d act=%b/%b exp=%b/1", k, ph, instr_done, P_E1); else pass_cnt++;
         tick();
         exp_ret++;
         total_cnt++; if (ph !== P_H) $display("FAIL stp_halt k=%0d act=%b exp=%b", k, ph, P_H); else pass_cnt++;
         tick();
         total_cnt++; if (ph !== P_H || retire_cnt !== 16'(exp_ret)) $display("FAIL stp_retire k=%0d act=%b/%0d exp=%b/%0d", k, ph, retire_cnt, P_H, exp_ret); else pass_cnt++;
         if (k == 0) begin
            start = 1'b1;
            tick();
            start = 1'b0;
            total_cnt++; if (ph !== P_F) $display("FAIL stp_restart act=%b exp=%b", ph, P_F); else pass_cnt++;
         end
      end
   endtask

   task automatic test_step();
      instr_in = 16'h8000; extra = 1'b0; extra2 = 1'b0; step = 1'b1;
      tick();
      step = 1'b0;
      total_cnt++; if (ph !== P_F) $display("FAIL step_fetch act=%b exp=%b", ph, P_F); else pass_cnt++;
      tick();
      total_cnt++; if (ph !== P_E1 || instr !== 16'h8000) $display("FAIL step_e1 act=%b/%h exp=%b/8000", ph, instr, P_E1); else pass_cnt++;
      tick();
      exp_ret++;
      total_cnt++; if (ph !== P_H || retire_cnt !== 16'(exp_ret)) $display("FAIL step_halt act=%b/%0d exp=%b/%0d", ph, retire_cnt, P_H, exp_ret); else pass_cnt++;
      tick();
      total_cnt++; if (ph !== P_H) $display("FAIL step_hold act=%b exp=%b", ph, P_H); else pass_cnt++;
      start = 1'b1; step = 1'b1;
      tick();
      start = 1'b0; step = 1'b0;
      for (int k = 0; k < 3; k++) begin
         tick();
         total_cnt++; if (ph !== P_E1) $display("FAIL start_step_e1 k=%0d act=%b exp=%b", k, ph, P_E1); else pass_cnt++;
         tick();
         exp_ret++;
         total_cnt++; if (ph !== P_F || retire_cnt !== 16'(exp_ret)) $display("FAIL start_step_run k=%0d act=%b/%0d exp=%b/%0d", k, ph, retire_cnt, P_F, exp_ret); else pass_cnt++;
      end
      tick();
      halt_req = 1'b1; start = 1'b1;
      tick();
      halt_req = 1'b0; start = 1'b0;
      exp_ret++;
      total_cnt++; if (ph !== P_H || retire_cnt !== 16'(exp_ret)) $display("FAIL halt_beats_start act=%b/%0d exp=%b/%0d", ph, retire_cnt, P_H, exp_ret); else pass_cnt++;
      halt_req = 1'b1;
      tick();
      halt_req = 1'b0;
      start = 1'b1;
      tick();
      start = 1'b0;
      total_cnt++; if (ph !== P_F) $display("FAIL resume_fetch act=%b exp=%b", ph, P_F); else pass_cnt++;
      tick(); tick();
      exp_ret++;
      total_cnt++; if (ph !== P_F || retire_cnt !== 16'(exp_ret)) $display("FAIL halt_req_in_halt_ignored act=%b/%0d exp=%b/%0d", ph, retire_cnt, P_F, exp_ret); else pass_cnt++;
   endtask

   task automatic test_wrap();
      w_reset = 1'b1; w_extra = 1'b0; w_extra2 = 1'b0;
      tick(); tick();
      w_reset = 1'b0;
      for (int k = 1; k <= 16; k++) begin
         tick(); tick();
         total_cnt++; if (w_ph !== P_F || w_retire !== 4'(k % 16)) $display("FAIL wrap_retire k=%0d act=%b/%0d exp=%b/%0d", k, w_ph, w_retire, P_F, k % 16); else pass_cnt++;
      end
      w_extra = 1'b1; w_extra2 = 1'b1;
      tick(); tick(); tick(); tick();
      total_cnt++; if (w_ph !== P_F || w_retire !== 4'd1) $display("FAIL wrap_four_cyc act=%b/%0d exp=%b/1", w_ph, w_retire, P_F); else pass_cnt++;
      tick(); tick();
      total_cnt++; if (w_ph !== P_E2) $display("FAIL mid_reset_e2 act=%b exp=%b", w_ph, P_E2); else pass_cnt++;
      w_reset = 1'b1;
      tick();
      w_reset = 1'b0;
      total_cnt++; if (w_ph !== P_F) $display("FAIL mid_reset_phase act=%b exp=%b", w_ph, P_F); else pass_cnt++;
      total_cnt++; if (w_retire !== 4'd0 || w_instr !== 16'h0) $display("FAIL mid_reset_state act=%0d/%h exp=0/0000", w_retire, w_instr); else pass_cnt++;
   endtask

   initial begin
      w_reset = 1'b1; w_extra = 1'b0; w_extra2 = 1'b0;
      test_reset();
      test_two_cycle();
      test_three_cycle();
      test_four_cycle_halt();
      test_stp();
      test_step();
      test_wrap();
      $display("%0d/%0d checks passed", pass_cnt, total_cnt);
      $finish;
   end

endmodule

`default_nettype wire
